// File: rtl/pb_fb_scan_fetch_if.sv
// Burst-read command and return-data bus between the scan-out fetch engine
// and the SDRAM controller.
interface pb_fb_scan_fetch_if #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 16
);
  logic                 sdr_cmd_bst_rd_req;
  logic [ADDR_BITS-1:0] sdr_cmd_addr;
  logic                 sdr_cmd_bst_rd_ack;
  logic [DATA_BITS-1:0] sdr_dout;
  logic                 sdr_r_vld;

  modport master (
    output sdr_cmd_bst_rd_req,
    output sdr_cmd_addr,
    input  sdr_cmd_bst_rd_ack,
    input  sdr_dout,
    input  sdr_r_vld
  );

  modport slave (
    input  sdr_cmd_bst_rd_req,
    input  sdr_cmd_addr,
    output sdr_cmd_bst_rd_ack,
    output sdr_dout,
    output sdr_r_vld
  );
endinterface

// File: rtl/pb_fb_scan_fetch.sv
// Framebuffer scan-out fetch: linear burst reads of one frame into a
// credit-gated show-ahead FIFO drained one pixel per pop.
module pb_fb_scan_fetch #(
  parameter int ADDR_BITS   = 24,
  parameter int DATA_BITS   = 16,
  parameter int BURST_WORDS = 32,
  parameter int FIFO_AW     = 7,
  parameter int FB_BASE     = 0,
  parameter int FRAME_WORDS = 307200
) (
  input  logic                  sdr_clk,
  input  logic                  sdr_rst,
  input  logic                  frame_start,
  pb_fb_scan_fetch_if.master    sdr,
  input  logic                  pix_rd,
  output logic [DATA_BITS-1:0]  pix_dout,
  output logic                  pix_vld,
  output logic                  underrun,
  output logic                  frame_done
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int OFF_W = $clog2(FRAME_WORDS + 1);
  localparam int CNT_W = $clog2(BURST_WORDS + 1);
  localparam logic [ADDR_BITS-1:0] BASE_A = ADDR_BITS'(FB_BASE);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic               discard_q, discard_d;
  logic               done_q, done_d;
  logic               under_q, under_d;
  logic [FIFO_AW:0]   wr_q, wr_d;
  logic [FIFO_AW:0]   rd_q, rd_d;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW:0]     level;
  logic                 push, pop;
  logic                 credit_ok;
  int                   outstanding;

  assign level     = wr_q - rd_q;
  assign pix_vld   = (level != '0);
  assign pix_dout  = mem[rd_q[FIFO_AW-1:0]];
  assign underrun  = under_q;
  assign frame_done = done_q;

  assign sdr.sdr_cmd_bst_rd_req = (state_q == S_REQ);
  assign sdr.sdr_cmd_addr       = BASE_A + ADDR_BITS'(offset_q);

  // Words still owed by the controller count against FIFO space.
  always_comb begin
    outstanding = 0;
    if ((state_q == S_REQ || state_q == S_RECV) && !discard_q)
      outstanding = BURST_WORDS - int'(cnt_q);
    credit_ok = (int'(level) + outstanding + BURST_WORDS) <= DEPTH;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    offset_d  = offset_q;
    discard_d = discard_q;
    done_d    = done_q;
    under_d   = under_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    push      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!done_q && credit_ok) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (sdr.sdr_cmd_bst_rd_ack) state_d = S_RECV;
      end
      S_RECV: begin
        if (sdr.sdr_r_vld) begin
          cnt_d = cnt_q + CNT_W'(1);
          push  = !discard_q;
          if (cnt_q == CNT_W'(BURST_WORDS - 1)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!sdr.sdr_cmd_bst_rd_ack) begin
          state_d = S_IDLE;
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            offset_d = offset_q + OFF_W'(BURST_WORDS);
            if (offset_d == OFF_W'(FRAME_WORDS)) done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    pop = pix_rd && pix_vld;
    if (pix_rd && !pix_vld) under_d = 1'b1;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;

    // A restart flushes at once; a burst already accepted is drained unpushed.
    if (frame_start) begin
      push     = 1'b0;
      pop      = 1'b0;
      wr_d     = '0;
      rd_d     = '0;
      offset_d = '0;
      done_d   = 1'b0;
      under_d  = 1'b0;
      if (state_q == S_IDLE || (state_q == S_REQ && !sdr.sdr_cmd_bst_rd_ack) ||
          (state_q == S_WAIT && !sdr.sdr_cmd_bst_rd_ack)) begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
      end else begin
        discard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sdr_clk or posedge sdr_rst) begin
    if (sdr_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      offset_q  <= '0;
      discard_q <= 1'b0;
      done_q    <= 1'b1;
      under_q   <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      discard_q <= discard_d;
      done_q    <= done_d;
      under_q   <= under_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  always_ff @(posedge sdr_clk) begin
    if (push) mem[wr_q[FIFO_AW-1:0]] <= sdr.sdr_dout;
  end

endmodule
